// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes,
// mul/div sequencing state encoding and register constants.
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32  = 7'b0111011;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse.sv
// Pure comparator: flags an ID instruction that reads the destination of a
// load currently in EX. Writes to x0 never create a dependency.
module hazard_loaduse_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       uses_rs1_ID,
  input  logic       uses_rs2_ID,
  input  logic [4:0] rd_EX,
  input  logic       is_load_EX,
  output logic       o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = uses_rs1_ID && (rs1_ID == rd_EX);
  assign w_rs2_hit = uses_rs2_ID && (rs2_ID == rd_EX);
  assign o_hazard  = is_load_EX && (rd_EX != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for IF/ID/EX: branch flush, mul/div hold-and-
// handshake sequencing with timeout, and load-use bubble insertion.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       uses_rs1_ID,
  input  logic       uses_rs2_ID,
  input  logic [4:0] rd_EX,
  input  logic       is_load_EX,
  input  logic       is_md_EX,
  input  logic       branch_taken_EX,
  input  logic       md_done,
  output logic       stall_IF,
  output logic       stall_ID,
  output logic       stall_EX,
  output logic       flush_ID,
  output logic       flush_EX,
  output logic       md_start,
  output logic       md_abort,
  output logic       md_error,
  output logic       state_o
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);

  md_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic              w_lu_hazard;
  logic              w_timeout;
  logic              w_stall_if, w_stall_id, w_stall_ex;
  logic              w_flush_id, w_flush_ex;
  logic              w_start, w_abort;

  hazard_loaduse_detect u_lu (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .uses_rs1_ID (uses_rs1_ID),
    .uses_rs2_ID (uses_rs2_ID),
    .rd_EX       (rd_EX),
    .is_load_EX  (is_load_EX),
    .o_hazard    (w_lu_hazard)
  );

  assign w_timeout = (r_cnt == CW'(MD_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_err_nxt   = r_err;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_stall_ex  = 1'b0;
    w_flush_id  = 1'b0;
    w_flush_ex  = 1'b0;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (branch_taken_EX) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (is_md_EX) begin
          w_start     = 1'b1;
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (w_lu_hazard) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
        end
      end
      ST_BUSY: begin
        // Release cycles drop all stalls so EX captures and advances at this edge.
        if (branch_taken_EX) begin
          w_flush_id  = 1'b1;
          w_flush_ex  = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (md_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          w_cnt_nxt  = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign stall_IF = reset & w_stall_if;
  assign stall_ID = reset & w_stall_id;
  assign stall_EX = reset & w_stall_ex;
  assign flush_ID = reset & w_flush_id;
  assign flush_EX = reset & w_flush_ex;
  assign md_start = reset & w_start;
  assign md_abort = reset & w_abort;
  assign md_error = r_err;
  assign state_o  = (r_state == ST_BUSY);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of single-cycle IDLE
// vectors plus hand-written multi-cycle mul/div, branch, timeout and reset runs.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
  logic       uses_rs1_ID = 0, uses_rs2_ID = 0, is_load_EX = 0, is_md_EX = 0;
  logic       branch_taken_EX = 0, md_done = 0;
  logic       stall_IF, stall_ID, stall_EX, flush_ID, flush_EX;
  logic       md_start, md_abort, md_error, state_o;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .rd_EX(rd_EX), .is_load_EX(is_load_EX), .is_md_EX(is_md_EX),
    .branch_taken_EX(branch_taken_EX), .md_done(md_done),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_ID(flush_ID), .flush_EX(flush_EX),
    .md_start(md_start), .md_abort(md_abort),
    .md_error(md_error), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Output vector bit order: {sIF,sID,sEX,fID,fEX,start,abort,err,state}
  localparam logic [8:0] Z   = 9'b000000000;
  localparam logic [8:0] LU  = 9'b110010000;
  localparam logic [8:0] FL  = 9'b000110000;
  localparam logic [8:0] ST  = 9'b111001000;
  localparam logic [8:0] BZ  = 9'b111000001;
  localparam logic [8:0] REL = 9'b000000001;
  localparam logic [8:0] BAB = 9'b000110101;
  localparam logic [8:0] TAB = 9'b000000101;
  localparam logic [8:0] ERR = 9'b000000010;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, md, br, done;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t  sbq[$];
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[12];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic u1, logic u2, logic ld,
                              logic md, logic br, logic done, logic [8:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.ld = ld; v.md = md; v.br = br; v.done = done;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX,
            md_start, md_abort, md_error, state_o};
  endfunction

  task automatic compare(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rs1_ID = v.rs1; rs2_ID = v.rs2; rd_EX = v.rd;
    uses_rs1_ID = v.u1; uses_rs2_ID = v.u2; is_load_EX = v.ld;
    is_md_EX = v.md; branch_taken_EX = v.br; md_done = v.done;
  endtask

  task automatic step(vec_t v);
    sb_t e;
    @(posedge clk); #1;
    apply(v);
    e.name = v.name; e.exp = v.exp;
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sbq.pop_front();
      compare(e.name, outs(), e.exp);
    end
  endtask

  // Shorthand for the mul/div sequences: only md/br/done vary.
  function automatic vec_t mdv(string n, logic md, logic br, logic done, logic [8:0] exp);
    return mk(n, 5'd0, 5'd0, 5'd0, 0, 0, 0, md, br, done, exp);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    tbl[1]  = mk("lu_rs1",        5, 0, 5, 1, 0, 1, 0, 0, 0, LU);
    tbl[2]  = mk("lu_rd_x0",      0, 0, 0, 1, 0, 1, 0, 0, 0, Z);
    tbl[3]  = mk("lu_rs2",        0, 5, 5, 0, 1, 1, 0, 0, 0, LU);
    tbl[4]  = mk("lu_rs1_unused", 5, 0, 5, 0, 0, 1, 0, 0, 0, Z);
    tbl[5]  = mk("no_load",       5, 5, 5, 1, 1, 0, 0, 0, 0, Z);
    tbl[6]  = mk("branch",        0, 0, 0, 0, 0, 0, 0, 1, 0, FL);
    tbl[7]  = mk("branch_over_lu",5, 0, 5, 1, 0, 1, 0, 1, 0, FL);
    tbl[8]  = mk("lu_rs2_only",   7, 7, 7, 0, 1, 1, 0, 0, 0, LU);
    tbl[9]  = mk("branch_no_start",0,0, 0, 0, 0, 0, 1, 1, 0, FL);
    tbl[10] = mk("done_in_idle",  0, 0, 0, 0, 0, 0, 0, 0, 1, Z);
    tbl[11] = mk("lu_mismatch",   4, 6, 5, 1, 1, 1, 0, 0, 0, Z);

    // Reset state with stimulus that would otherwise start the md unit.
    is_md_EX = 1; branch_taken_EX = 1;
    #3 compare("reset_outs", outs(), Z);
    @(negedge clk);
    compare("reset_outs_hold", outs(), Z);
    is_md_EX = 0; branch_taken_EX = 0;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) step(tbl[i]);

    // Normal md: start at cycle 0, done at cycle 6.
    step(mdv("md_start", 1, 0, 0, ST));
    for (int i = 1; i < 6; i++) step(mdv($sformatf("md_busy%0d", i), 1, 0, 0, BZ));
    step(mdv("md_done_rel", 1, 0, 1, REL));
    step(mdv("md_idle_after", 0, 0, 0, Z));

    // Branch during BUSY at cycle 3, then again with md_done in the same cycle.
    for (int k = 0; k < 2; k++) begin
      step(mdv("br_start", 1, 0, 0, ST));
      step(mdv("br_busy1", 1, 0, 0, BZ));
      step(mdv("br_busy2", 1, 0, 0, BZ));
      step(mdv(k == 0 ? "br_abort" : "br_abort_done", 1, 1, k == 1, BAB));
      step(mdv("br_idle", 0, 0, 0, Z));
    end

    // Load-use together with md: md wins, bubble follows release.
    step(mk("pri_start", 5, 0, 5, 1, 0, 1, 1, 0, 0, ST));
    step(mk("pri_busy",  5, 0, 5, 1, 0, 1, 1, 0, 0, BZ));
    step(mk("pri_rel",   5, 0, 5, 1, 0, 1, 1, 0, 1, REL));
    step(mk("pri_lu",    5, 0, 5, 1, 0, 1, 0, 0, 0, LU));
    step(mdv("pri_clear", 0, 0, 0, Z));

    // Timeout: TO stall cycles in BUSY, then abort; error sticks.
    step(mdv("to_start", 1, 0, 0, ST));
    for (int i = 0; i < TO; i++) step(mdv($sformatf("to_busy%0d", i), 1, 0, 0, BZ));
    step(mdv("to_abort", 1, 0, 0, TAB));
    step(mdv("to_err", 0, 0, 0, ERR));
    step(mk("to_err_lu", 5, 0, 5, 1, 0, 1, 0, 0, 0, LU | ERR));
    step(mdv("to_err_done_idle", 0, 0, 1, ERR));

    // Async reset mid-BUSY.
    step(mdv("rst_start", 1, 0, 0, ST | ERR));
    step(mdv("rst_busy", 1, 0, 0, BZ | ERR));
    @(posedge clk); #2;
    reset = 1'b0;
    #1 compare("rst_async_outs", outs(), Z);
    @(negedge clk);
    compare("rst_held", outs(), Z);
    apply(mdv("x", 0, 0, 0, Z));
    reset = 1'b1;
    step(mdv("post_rst_idle", 0, 0, 0, Z));
    step(mdv("post_rst_start", 1, 0, 0, ST));
    step(mdv("post_rst_rel", 1, 0, 1, REL));
    step(mdv("post_rst_end", 0, 0, 0, Z));

    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It produces the stall and flush signals for IF/ID/EX:
- load-use bubbles;
- branch/jump flushes driven by the registered branch_taken_EX;
- hold-and-handshake sequencing of a multi-cycle M-extension (mul/div) unit that shares the EX slot.

It sits beside the pipeline registers and drives their hold/clear inputs. It never touches data.

Parameters:
MD_TIMEOUT, 127, max BUSY cycles before forced release; counter width = $clog2(MD_TIMEOUT+1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low
rs1_ID  input  5  source reg 1 of instruction in ID
rs2_ID  input  5  source reg 2 of instruction in ID
uses_rs1_ID  input  1  ID instruction reads rs1
uses_rs2_ID  input  1  ID instruction reads rs2
rd_EX  input  5  destination of instruction in EX
is_load_EX  input  1  EX instruction is a load (dm_rd_ctrl != 0)
is_md_EX  input  1  EX instruction is a mul/div op
branch_taken_EX  input  1  registered branch/jump taken (instruction now in MEM)
md_done  input  1  mul/div unit result valid (1-cycle pulse)
stall_IF  output  1  hold PC
stall_ID  output  1  hold IF/ID register
stall_EX  output  1  hold ID/EX register
flush_ID  output  1  clear IF/ID register (insert NOP)
flush_EX  output  1  clear ID/EX register (insert bubble)
md_start  output  1  1-cycle start pulse to mul/div unit
md_abort  output  1  1-cycle abort pulse to mul/div unit
md_error  output  1  sticky timeout flag
state_o  output  1  FSM state, 0=IDLE 1=BUSY (debug)

Behaviour:
- Reset (async, low): FSM=IDLE, counter=0, md_error=0. All outputs 0 while reset is low. Reset mid-BUSY returns to IDLE immediately; no abort pulse is issued.
- Stall/flush outputs are combinational from inputs plus state. md_error is registered.
- Priority: branch flush > md sequencing > load-use.

Branch:
- If branch_taken_EX=1: flush_ID=1, flush_EX=1, and all stalls=0 that cycle.
- If in BUSY: md_abort=1 for that cycle and FSM->IDLE next edge (the md instruction is younger than the branch and is killed).
- If in IDLE: md_start is suppressed even when is_md_EX=1.

Load-use:
- Hazard when is_load_EX && rd_EX!=0 && ((uses_rs1_ID && rs1_ID==rd_EX) || (uses_rs2_ID && rs2_ID==rd_EX)).
- Active only when FSM=IDLE, not starting md, and no branch.
- Response: stall_IF=stall_ID=1 and flush_EX=1 for exactly one cycle.

MD FSM:
- IDLE, is_md_EX=1, no branch:
  - md_start=1 and stall_IF=stall_ID=stall_EX=1.
  - Next state BUSY, counter=0.
- BUSY:
  - stall_IF/ID/EX=1 and counter += 1 each cycle.
  - On md_done=1: all stalls=0 that same cycle, so EX registers the result and advances at that edge. Next state IDLE.
  - On counter==MD_TIMEOUT without done: same release as md_done, plus md_error<=1 (sticky until reset) and md_abort=1. Next state IDLE.
- md_done in IDLE is ignored.
- md_done and branch_taken_EX in the same BUSY cycle: branch wins, so abort and flush.
- A load-use hazard pending during BUSY is masked. It re-evaluates after release; no flush_EX is issued while stall_EX=1.
- Minimum md latency is 2 cycles: start cycle plus at least one BUSY cycle. md_done in the start cycle is ignored.

Decomposition:
- Shared package: OPCODE_* constants (load, branch, jal, jalr, OP-32/M-ext), FSM state encoding IDLE/BUSY, REG_X0=5'd0.
- Optional sub-module: hazard_loaduse_detect (pure comparator). Keep the FSM and priority logic in this module.

Test Plan:
- Load-use: is_load_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 -> one cycle of stall_IF=stall_ID=flush_EX=1, then all 0. Same stimulus with rd_EX=0 -> no stall.
- MD normal: is_md_EX=1 at cycle 0, md_done at cycle 6 -> md_start pulse at cycle 0 only. stall_* high cycles 0-5, low at cycle 6. state_o back to 0 at cycle 7.
- Branch during BUSY: md started at cycle 0, branch_taken_EX=1 at cycle 3 -> cycle 3 shows md_abort=1, flush_ID=flush_EX=1, stalls 0. IDLE at cycle 4. Same test with md_done also at cycle 3 -> identical response.
- Timeout: MD_TIMEOUT=7, md_done never asserted -> release with md_abort after 7 BUSY cycles. md_error=1 from the next edge and stays 1 until reset.
- Priority: load-use hazard and is_md_EX together -> md stall only, flush_EX=0. Load-use bubble appears in the cycle after release.
- Async reset asserted mid-BUSY (between clock edges) -> outputs 0 immediately. state_o=0 and md_error=0 after reset deasserts.
